// File: rtl/ase_umsg_engine.sv
// UMsg hint/data delivery engine: per-slot latch + delay FSMs, round-robin
// arbitration onto one registered valid/ready CCI-P RX0 output.
module ase_umsg_engine #(
  parameter int NUM_UMSG   = 32,
  parameter int DATA_WIDTH = 512,
  parameter int TIMER_W    = 8,
  parameter int HINT_DELAY = 16,
  parameter int DATA_DELAY = 32,
  localparam int ID_W      = (NUM_UMSG > 1) ? $clog2(NUM_UMSG) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  umsg_wr_valid,
  input  logic [ID_W-1:0]       umsg_wr_id,
  input  logic [DATA_WIDTH-1:0] umsg_wr_data,
  input  logic [NUM_UMSG-1:0]   umsg_hint_en,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic [27:0]           rx_hdr,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic [NUM_UMSG-1:0]   slot_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHANGE,
    S_SEND_HINT,
    S_WAITING,
    S_SEND_DATA
  } slot_state_e;

  localparam logic [TIMER_W-1:0] HINT_LAST = TIMER_W'(HINT_DELAY - 1);
  localparam logic [TIMER_W-1:0] DATA_LAST = TIMER_W'(DATA_DELAY - 1);
  localparam logic [3:0]         RESP_UMSG = 4'hF;

  slot_state_e             state_q [NUM_UMSG];
  slot_state_e             state_d [NUM_UMSG];
  logic [TIMER_W-1:0]      timer_q [NUM_UMSG];
  logic [TIMER_W-1:0]      timer_d [NUM_UMSG];
  logic [DATA_WIDTH-1:0]   data_q  [NUM_UMSG];
  logic [NUM_UMSG-1:0]     hint_q;
  logic [NUM_UMSG-1:0]     req;
  logic [NUM_UMSG-1:0]     wr_sel;
  logic                    wr_hit;
  logic [ID_W-1:0]         rr_ptr;

  logic                    out_free;
  logic                    grant_valid;
  logic [ID_W-1:0]         grant_id;
  logic                    grant_hint;
  logic [DATA_WIDTH-1:0]   grant_data;
  logic [15:0]             grant_mdata;

  assign wr_hit   = umsg_wr_valid && (int'(umsg_wr_id) < NUM_UMSG);
  assign out_free = !rx_valid || rx_ready;

  always_comb begin
    for (int i = 0; i < NUM_UMSG; i++) begin
      req[i]       = (state_q[i] == S_SEND_HINT) || (state_q[i] == S_SEND_DATA);
      wr_sel[i]    = wr_hit && (umsg_wr_id == ID_W'(i));
      slot_busy[i] = (state_q[i] != S_IDLE);
    end
  end

  // Round-robin search starting at rr_ptr; first requester found wins.
  always_comb begin
    int idx;
    idx         = 0;
    grant_valid = 1'b0;
    grant_id    = '0;
    grant_hint  = 1'b0;
    grant_data  = '0;
    for (int k = 0; k < NUM_UMSG; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_UMSG) idx = idx - NUM_UMSG;
      if (out_free && !grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant_id    = ID_W'(idx);
        grant_hint  = (state_q[idx] == S_SEND_HINT);
        grant_data  = (state_q[idx] == S_SEND_HINT) ? '0 : data_q[idx];
      end
    end
  end

  always_comb begin
    grant_mdata             = '0;
    grant_mdata[ID_W-1:0]   = grant_id;
    grant_mdata[12]         = grant_hint;
  end

  always_comb begin
    for (int i = 0; i < NUM_UMSG; i++) begin
      state_d[i] = state_q[i];
      timer_d[i] = timer_q[i];
      unique case (state_q[i])
        S_CHANGE: begin
          if (!hint_q[i]) begin
            state_d[i] = S_WAITING;
            timer_d[i] = '0;
          end else if (timer_q[i] == HINT_LAST) begin
            state_d[i] = S_SEND_HINT;
            timer_d[i] = '0;
          end else begin
            timer_d[i] = timer_q[i] + 1'b1;
          end
        end
        S_SEND_HINT: begin
          if (grant_valid && grant_id == ID_W'(i)) begin
            state_d[i] = S_WAITING;
            timer_d[i] = '0;
          end
        end
        S_WAITING: begin
          if (timer_q[i] == DATA_LAST) begin
            state_d[i] = S_SEND_DATA;
            timer_d[i] = '0;
          end else begin
            timer_d[i] = timer_q[i] + 1'b1;
          end
        end
        S_SEND_DATA: begin
          if (grant_valid && grant_id == ID_W'(i)) state_d[i] = S_IDLE;
        end
        default: ;
      endcase
      // NOTE: a write overrides whatever the slot FSM decided this cycle; a
      // simultaneous grant still issues because the output samples pre-write data_q.
      if (wr_sel[i]) begin
        state_d[i] = S_CHANGE;
        timer_d[i] = '0;
      end
    end
  end

  // NOTE: the payload array is reset too, so a dropped UMsg leaves no stale data behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_UMSG; i++) begin
        state_q[i] <= S_IDLE;
        timer_q[i] <= '0;
        data_q[i]  <= '0;
      end
      hint_q <= '0;
    end else begin
      for (int i = 0; i < NUM_UMSG; i++) begin
        state_q[i] <= state_d[i];
        timer_q[i] <= timer_d[i];
        if (wr_sel[i]) begin
          data_q[i] <= umsg_wr_data;
          hint_q[i] <= umsg_hint_en[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      rx_valid <= 1'b0;
      rx_hdr   <= '0;
      rx_data  <= '0;
    end else if (grant_valid) begin
      rr_ptr   <= (grant_id == ID_W'(NUM_UMSG - 1)) ? '0 : grant_id + 1'b1;
      rx_valid <= 1'b1;
      rx_hdr   <= {8'h00, RESP_UMSG, grant_mdata};
      rx_data  <= grant_data;
    end else if (rx_ready) begin
      rx_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ase_umsg_engine.sv
// Directed bench for ase_umsg_engine: default build plus a 5-slot/DATA_DELAY=1
// build and a single-slot build for the boundary latencies.
module tb_ase_umsg_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         wr_valid = 1'b0;
  logic [4:0]   wr_id = '0;
  logic [511:0] wr_data = '0;
  logic [31:0]  hint_en = '0;
  logic         rx_ready = 1'b0;
  logic         rx_valid;
  logic [27:0]  rx_hdr;
  logic [511:0] rx_data;
  logic [31:0]  slot_busy;

  logic         s_wr_valid = 1'b0;
  logic [2:0]   s_wr_id = '0;
  logic [31:0]  s_wr_data = '0;
  logic [4:0]   s_hint_en = '0;
  logic         s_rx_ready = 1'b0;
  logic         s_rx_valid;
  logic [27:0]  s_rx_hdr;
  logic [31:0]  s_rx_data;
  logic [4:0]   s_slot_busy;

  logic         o_wr_valid = 1'b0;
  logic [0:0]   o_wr_id = '0;
  logic [15:0]  o_wr_data = '0;
  logic [0:0]   o_hint_en = '0;
  logic         o_rx_ready = 1'b0;
  logic         o_rx_valid;
  logic [27:0]  o_rx_hdr;
  logic [15:0]  o_rx_data;
  logic [0:0]   o_slot_busy;

  int checks = 0;
  int errors = 0;

  ase_umsg_engine dut (
    .clk(clk), .rst_n(rst_n),
    .umsg_wr_valid(wr_valid), .umsg_wr_id(wr_id), .umsg_wr_data(wr_data),
    .umsg_hint_en(hint_en), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_hdr(rx_hdr), .rx_data(rx_data), .slot_busy(slot_busy)
  );

  ase_umsg_engine #(.NUM_UMSG(5), .DATA_WIDTH(32), .HINT_DELAY(2), .DATA_DELAY(1)) dut_small (
    .clk(clk), .rst_n(rst_n),
    .umsg_wr_valid(s_wr_valid), .umsg_wr_id(s_wr_id), .umsg_wr_data(s_wr_data),
    .umsg_hint_en(s_hint_en), .rx_valid(s_rx_valid), .rx_ready(s_rx_ready),
    .rx_hdr(s_rx_hdr), .rx_data(s_rx_data), .slot_busy(s_slot_busy)
  );

  ase_umsg_engine #(.NUM_UMSG(1), .DATA_WIDTH(16), .HINT_DELAY(1), .DATA_DELAY(3)) dut_one (
    .clk(clk), .rst_n(rst_n),
    .umsg_wr_valid(o_wr_valid), .umsg_wr_id(o_wr_id), .umsg_wr_data(o_wr_data),
    .umsg_hint_en(o_hint_en), .rx_valid(o_rx_valid), .rx_ready(o_rx_ready),
    .rx_hdr(o_rx_hdr), .rx_data(o_rx_data), .slot_busy(o_slot_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write lands on the next edge (cycle T); returns one cycle later (T+1).
  task automatic do_write(input logic [4:0] id, input logic [511:0] d, input logic [31:0] he);
    wr_valid = 1'b1; wr_id = id; wr_data = d; hint_en = he;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic s_write(input logic [2:0] id, input logic [31:0] d, input logic [4:0] he);
    s_wr_valid = 1'b1; s_wr_id = id; s_wr_data = d; s_hint_en = he;
    tick();
    s_wr_valid = 1'b0;
  endtask

  task automatic o_write(input logic [0:0] id, input logic [15:0] d, input logic [0:0] he);
    o_wr_valid = 1'b1; o_wr_id = id; o_wr_data = d; o_hint_en = he;
    tick();
    o_wr_valid = 1'b0;
  endtask

  // n=1 means the current cycle; returns -1 if rx_valid never rose within max cycles.
  task automatic wait_valid(input int max, output int n);
    n = 1;
    while (!rx_valid && n < max) begin
      tick();
      n++;
    end
    if (!rx_valid) n = -1;
  endtask

  task automatic test_reset();
    int n, seen;
    rst_n = 1'b0; rx_ready = 1'b0;
    repeat (2) tick();
    checks++;
    if ({rx_valid, rx_hdr, slot_busy, s_rx_valid, s_slot_busy, o_rx_valid, o_slot_busy} !== '0 || rx_data !== '0) begin
      errors++;
      $display("FAIL reset_state: valid=%b hdr=%h busy=%h s_valid=%b o_valid=%b, required all zero",
               rx_valid, rx_hdr, slot_busy, s_rx_valid, o_rx_valid);
    end
    rst_n = 1'b1;
    tick();
    do_write(5'd4, 512'h4, 32'h0);
    do_write(5'd5, 512'h5, 32'h0);
    do_write(5'd6, 512'h6, 32'h0);
    wait_valid(60, n);
    checks++;
    if (n != 33) begin
      errors++; $display("FAIL reset_pre_latency: got %0d required 33", n);
    end
    checks++;
    if (slot_busy !== 32'h0000_0060) begin
      errors++; $display("FAIL reset_pre_busy: got %h required 00000060", slot_busy);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (rx_valid !== 1'b0 || rx_hdr !== '0 || rx_data !== '0 || slot_busy !== '0) begin
      errors++;
      $display("FAIL reset_midflight: valid=%b hdr=%h busy=%h, required all zero", rx_valid, rx_hdr, slot_busy);
    end
    tick();
    rst_n = 1'b1; rx_ready = 1'b1;
    seen = 0;
    repeat (80) begin
      tick();
      if (rx_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL reset_no_stale: %0d valid cycles seen, required 0", seen);
    end
  endtask

  task automatic test_no_hint();
    int n;
    logic [511:0] d;
    d = {64{8'hA5}};
    rx_ready = 1'b1;
    do_write(5'd5, d, 32'hFFFF_FFDF);
    checks++;
    if (slot_busy !== 32'h0000_0020) begin
      errors++; $display("FAIL nohint_busy: got %h required 00000020", slot_busy);
    end
    wait_valid(100, n);
    checks++;
    if (n != 35) begin
      errors++; $display("FAIL nohint_latency: got %0d required 35", n);
    end
    checks++;
    if (rx_hdr !== 28'h00F_0005 || rx_data !== d) begin
      errors++; $display("FAIL nohint_msg: hdr=%h data=%h required hdr 00f0005 data a5..", rx_hdr, rx_data);
    end
    tick();
    checks++;
    if (rx_valid !== 1'b0 || slot_busy !== '0) begin
      errors++; $display("FAIL nohint_single: valid=%b busy=%h required 0/0", rx_valid, slot_busy);
    end
  endtask

  task automatic test_hint();
    int n, m;
    logic [511:0] d;
    d = {16{32'h3C3C_0003}};
    rx_ready = 1'b1;
    do_write(5'd3, d, 32'h0000_0008);
    hint_en = '0;
    wait_valid(100, n);
    checks++;
    if (n != 18) begin
      errors++; $display("FAIL hint_latency: got %0d required 18", n);
    end
    checks++;
    if (rx_hdr !== 28'h00F_1003 || rx_data !== '0) begin
      errors++; $display("FAIL hint_msg: hdr=%h data=%h required hdr 00f1003 data 0", rx_hdr, rx_data);
    end
    tick();
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++; $display("FAIL hint_gap: valid=%b required 0", rx_valid);
    end
    wait_valid(100, m);
    checks++;
    if (m < 0 || n + m != 51) begin
      errors++; $display("FAIL hint_data_latency: got %0d required 51", (m < 0) ? -1 : n + m);
    end
    checks++;
    if (rx_hdr !== 28'h00F_0003 || rx_data !== d) begin
      errors++; $display("FAIL hint_data_msg: hdr=%h data=%h required hdr 00f0003", rx_hdr, rx_data);
    end
    tick();
  endtask

  task automatic test_coalesce();
    int n, seen;
    rx_ready = 1'b1;
    do_write(5'd7, 512'h11, 32'h0);
    repeat (9) tick();
    do_write(5'd7, 512'h22, 32'h0);
    wait_valid(100, n);
    checks++;
    if (n != 35) begin
      errors++; $display("FAIL coalesce_latency: got %0d required 35", n);
    end
    checks++;
    if (rx_hdr !== 28'h00F_0007 || rx_data !== 512'h22) begin
      errors++; $display("FAIL coalesce_msg: hdr=%h data=%h required hdr 00f0007 data 22", rx_hdr, rx_data);
    end
    seen = 0;
    repeat (50) begin
      tick();
      if (rx_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL coalesce_single: %0d extra valid cycles, required 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    rx_ready = 1'b0;
    do_write(5'd0, 512'hD0, 32'h0);
    do_write(5'd1, 512'hD1, 32'h0);
    do_write(5'd2, 512'hD2, 32'h0);
    wait_valid(60, n);
    checks++;
    if (n != 33 || rx_hdr !== 28'h00F_0000 || rx_data !== 512'hD0) begin
      errors++; $display("FAIL arb_first: n=%0d hdr=%h data=%h required 33/00f0000/d0", n, rx_hdr, rx_data[31:0]);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if ({rx_valid, rx_hdr} !== {1'b1, 28'h00F_0000} || rx_data !== 512'hD0) begin
        errors++; $display("FAIL arb_stall_%0d: valid=%b hdr=%h required 1/00f0000", c, rx_valid, rx_hdr);
      end
    end
    rx_ready = 1'b1;
    tick();
    checks++;
    if ({rx_valid, rx_hdr} !== {1'b1, 28'h00F_0001} || rx_data !== 512'hD1) begin
      errors++; $display("FAIL arb_second: valid=%b hdr=%h required 1/00f0001", rx_valid, rx_hdr);
    end
    tick();
    checks++;
    if ({rx_valid, rx_hdr} !== {1'b1, 28'h00F_0002} || rx_data !== 512'hD2) begin
      errors++; $display("FAIL arb_third: valid=%b hdr=%h required 1/00f0002", rx_valid, rx_hdr);
    end
    tick();
    checks++;
    if (rx_valid !== 1'b0 || dut.rr_ptr !== 5'd3) begin
      errors++; $display("FAIL arb_done: valid=%b rr_ptr=%0d required 0/3", rx_valid, dut.rr_ptr);
    end
  endtask

  task automatic test_boundary_small();
    int seen;
    s_rx_ready = 1'b1;
    s_write(3'd5, 32'h55, 5'h1F);
    s_write(3'd7, 32'h77, 5'h1F);
    checks++;
    if (s_slot_busy !== '0) begin
      errors++; $display("FAIL small_oor_busy: got %h required 0", s_slot_busy);
    end
    seen = 0;
    repeat (10) begin
      if (s_rx_valid) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL small_oor_msg: %0d valid cycles, required 0", seen);
    end
    s_write(3'd4, 32'hCAFE_0004, 5'h00);
    tick(); tick();
    checks++;
    if (s_rx_valid !== 1'b0) begin
      errors++; $display("FAIL small_early: valid=%b at T+3, required 0", s_rx_valid);
    end
    tick();
    checks++;
    if ({s_rx_valid, s_rx_hdr} !== {1'b1, 28'h00F_0004} || s_rx_data !== 32'hCAFE_0004) begin
      errors++; $display("FAIL small_data: valid=%b hdr=%h data=%h required 1/00f0004/cafe0004", s_rx_valid, s_rx_hdr, s_rx_data);
    end
    tick();
    s_write(3'd2, 32'h0000_2222, 5'h04);
    tick(); tick(); tick();
    checks++;
    if ({s_rx_valid, s_rx_hdr} !== {1'b1, 28'h00F_1002} || s_rx_data !== '0) begin
      errors++; $display("FAIL small_hint: valid=%b hdr=%h data=%h required 1/00f1002/0", s_rx_valid, s_rx_hdr, s_rx_data);
    end
    tick();
    checks++;
    if (s_rx_valid !== 1'b0) begin
      errors++; $display("FAIL small_hint_gap: valid=%b required 0", s_rx_valid);
    end
    tick();
    checks++;
    if ({s_rx_valid, s_rx_hdr} !== {1'b1, 28'h00F_0002} || s_rx_data !== 32'h0000_2222) begin
      errors++; $display("FAIL small_hint_data: valid=%b hdr=%h data=%h required 1/00f0002/2222", s_rx_valid, s_rx_hdr, s_rx_data);
    end
    tick();
  endtask

  task automatic test_boundary_one();
    o_rx_ready = 1'b1;
    o_write(1'b1, 16'h1111, 1'b1);
    checks++;
    if (o_slot_busy !== 1'b0) begin
      errors++; $display("FAIL one_oor_busy: got %b required 0", o_slot_busy);
    end
    o_write(1'b0, 16'hBEEF, 1'b0);
    repeat (4) tick();
    checks++;
    if (o_rx_valid !== 1'b0) begin
      errors++; $display("FAIL one_early: valid=%b at T+5, required 0", o_rx_valid);
    end
    tick();
    checks++;
    if ({o_rx_valid, o_rx_hdr} !== {1'b1, 28'h00F_0000} || o_rx_data !== 16'hBEEF) begin
      errors++; $display("FAIL one_data: valid=%b hdr=%h data=%h required 1/00f0000/beef", o_rx_valid, o_rx_hdr, o_rx_data);
    end
    tick();
    o_write(1'b0, 16'h5A5A, 1'b1);
    tick(); tick();
    checks++;
    if ({o_rx_valid, o_rx_hdr} !== {1'b1, 28'h00F_1000} || o_rx_data !== '0) begin
      errors++; $display("FAIL one_hint: valid=%b hdr=%h data=%h required 1/00f1000/0", o_rx_valid, o_rx_hdr, o_rx_data);
    end
    repeat (3) tick();
    checks++;
    if (o_rx_valid !== 1'b0) begin
      errors++; $display("FAIL one_hint_gap: valid=%b at T+6, required 0", o_rx_valid);
    end
    tick();
    checks++;
    if ({o_rx_valid, o_rx_hdr} !== {1'b1, 28'h00F_0000} || o_rx_data !== 16'h5A5A) begin
      errors++; $display("FAIL one_hint_data: valid=%b hdr=%h data=%h required 1/00f0000/5a5a", o_rx_valid, o_rx_hdr, o_rx_data);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_no_hint();
    test_hint();
    test_coalesce();
    test_back_to_back();
    test_boundary_small();
    test_boundary_one();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
